signal_reduction: RTL and testbench

//  Inverse of the address sign-extension path. Narrows a DB-bit two's-complement

---
 rtl/signal_reduction.sv | 126 ++++++++++++
 tb/tb_signal_reduction.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_reduction.sv
// Narrows a DB-bit signed datapath word to an AB-bit signed address/immediate,
// flagging words that do not fit and either saturating or wrapping them.
module signal_reduction #(
  parameter int AB    = 11,
  parameter int DB    = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DB-1:0]    in_data,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AB-1:0]    out_data,
  output logic             out_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count,
  input  logic             clr_stat
);

  function automatic logic fits_f(input logic signed [DB-1:0] x);
    logic [DB-AB:0] top;
    top = x[DB-1:AB-1];
    return (&top) | ~(|top);
  endfunction

  function automatic logic [AB-1:0] narrow_f(input logic signed [DB-1:0] x, input logic sat);
    if (fits_f(x) || !sat)
      return x[AB-1:0];
    else if (x[DB-1])
      return {1'b1, {(AB-1){1'b0}}};
    else
      return {1'b0, {(AB-1){1'b1}}};
  endfunction

  // Stage p0: combinational fit test and narrowing of the incoming word
  logic signed [DB-1:0] in_word_p0;
  logic        [AB-1:0] res_data_p0;
  logic                 res_ovf_p0;
  logic                 push, pop;

  assign in_word_p0  = in_data;
  assign res_ovf_p0  = ~fits_f(in_word_p0);
  assign res_data_p0 = narrow_f(in_word_p0, sat_en);

  // Stage p1: two-entry output buffer; head drives the outputs directly
  logic [1:0]       count_q, count_d;
  logic [AB-1:0]    head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic             head_ovf_q, head_ovf_d, tail_ovf_q, tail_ovf_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_ready  = !reset && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_ovf_d  = head_ovf_q;
    tail_data_d = tail_data_q;
    tail_ovf_d  = tail_ovf_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
      if (count_q == 2'd0) begin
        head_data_d = res_data_p0;
        head_ovf_d  = res_ovf_p0;
      end else begin
        tail_data_d = res_data_p0;
        tail_ovf_d  = res_ovf_p0;
      end
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
      if (count_q == 2'd2) begin
        head_data_d = tail_data_q;
        head_ovf_d  = tail_ovf_q;
      end
    end else if (push && pop) begin
      // Only reachable with one entry: the new word replaces the departing head.
      head_data_d = res_data_p0;
      head_ovf_d  = res_ovf_p0;
    end
  end

  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (clr_stat) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (push && res_ovf_p0) begin
      sticky_d = 1'b1;
      cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= 2'd0;
      head_data_q <= '0;
      head_ovf_q  <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      count_q     <= count_d;
      head_data_q <= head_data_d;
      head_ovf_q  <= head_ovf_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tail_data_q <= tail_data_d;
    tail_ovf_q  <= tail_ovf_d;
  end

  assign out_data   = head_data_q;
  assign out_ovf    = head_ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_signal_reduction.sv
// Scoreboard bench for signal_reduction: driver queues expected results,
// a monitor pops and compares whenever the DUT hands a word over.
module tb_signal_reduction;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, sat_en, out_valid, out_ready;
  logic        out_ovf, ovf_sticky, clr_stat;
  logic [15:0] in_data;
  logic [10:0] out_data;
  logic [7:0]  ovf_count;

  int nchk = 0;
  int nerr = 0;
  logic [11:0] expq[$];
  int   m_cnt    = 0;
  logic m_sticky = 1'b0;

  signal_reduction #(.AB(11), .DB(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .sat_en(sat_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .ovf_sticky(ovf_sticky), .ovf_count(ovf_count), .clr_stat(clr_stat)
  );

  always #5 clk = ~clk;

  // Reference: returns {ovf, data} from the integer value of the word.
  function automatic logic [11:0] model(input logic [15:0] w, input logic sat);
    int v;
    logic [11:0] r;
    v = int'($signed(w));
    if (v >= -1024 && v <= 1023) r = {1'b0, v[10:0]};
    else if (sat)                r = (v > 0) ? {1'b1, 11'h3FF} : {1'b1, 11'h400};
    else                         r = {1'b1, v[10:0]};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: each handshake seen before an edge consumes one expected word.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_out", {21'd0, out_ovf, out_data}, 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        chk("out_data", {21'd0, out_data}, {21'd0, e[10:0]});
        chk("out_ovf", {31'd0, out_ovf}, {31'd0, e[11]});
      end
    end
  end

  // Statistics model, evaluated with the values present just before each edge.
  always @(posedge clk) begin
    logic [11:0] r;
    r = model(in_data, sat_en);
    if (reset || clr_stat) begin
      m_cnt    <= 0;
      m_sticky <= 1'b0;
    end else if (in_valid && in_ready && r[11]) begin
      m_cnt    <= (m_cnt == 255) ? 255 : m_cnt + 1;
      m_sticky <= 1'b1;
    end
  end

  // Called and returning at posedge+1; the word is queued when it is accepted.
  task automatic send(input logic [15:0] w, input logic sat);
    int   t;
    logic ok;
    t = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    sat_en   = sat;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) expq.push_back(model(w, sat));
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (expq.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", expq.size(), 32'd0);
  endtask

  task automatic check_stats(input string name);
    chk({name, "_cnt"}, {24'd0, ovf_count}, m_cnt);
    chk({name, "_sticky"}, {31'd0, ovf_sticky}, {31'd0, m_sticky});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bnd[8];
    logic [15:0] t1[3];
    logic [10:0] t1e[3];
    logic [15:0] w;
    int r;
    bnd = '{16'h03FF, 16'h0400, 16'hFC00, 16'hFBFF, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
    t1  = '{16'h03FF, 16'hFC00, 16'hFFFF};
    t1e = '{11'h3FF, 11'h400, 11'h7FF};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; sat_en = 1'b1;
    out_ready = 1'b1; clr_stat = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_out_data", {21'd0, out_data}, 32'd0);
    chk("post_rst_out_ovf", {31'd0, out_ovf}, 32'd0);
    check_stats("post_rst");
    @(posedge clk); #1;

    // In-range words appear one cycle after acceptance.
    for (int i = 0; i < 3; i++) begin
      send(t1[i], 1'b1);
      @(negedge clk);
      chk("lat_valid", {31'd0, out_valid}, 32'd1);
      chk("lat_data", {21'd0, out_data}, {21'd0, t1e[i]});
      @(posedge clk); #1;
    end

    // Saturation, then wrap.
    send(16'h0400, 1'b1);
    send(16'h7FFF, 1'b1);
    send(16'h8000, 1'b1);
    send(16'hFBFF, 1'b1);
    drain();
    @(negedge clk);
    chk("sat_cnt", {24'd0, ovf_count}, 32'd4);
    chk("sat_sticky", {31'd0, ovf_sticky}, 32'd1);
    @(posedge clk); #1;
    send(16'h0400, 1'b0);
    send(16'h1234, 1'b0);
    drain();

    // Backpressure: two words fill the buffer and the head is held.
    out_ready = 1'b0;
    send(16'h0123, 1'b1);
    send(16'h0456, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {21'd0, out_data}, 32'h123);
      @(posedge clk); #1;
    end
    drain();
    @(negedge clk);
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Random valid/ready traffic.
    for (int c = 0; c < 1500; c++) begin
      case ($urandom % 4)
        0: w = bnd[$urandom % 8];
        1: begin r = int'($urandom_range(2047, 0)) - 1024; w = r[15:0]; end
        default: w = 16'($urandom);
      endcase
      in_valid  = ($urandom % 3) != 0;
      in_data   = w;
      sat_en    = $urandom % 2;
      out_ready = ($urandom % 4) != 0;
      @(negedge clk);
      if (in_valid && in_ready) expq.push_back(model(in_data, sat_en));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    @(negedge clk);
    check_stats("rand");
    @(posedge clk); #1;

    // Counter saturation and clear priority.
    clr_stat = 1'b1;
    @(posedge clk); #1;
    clr_stat = 1'b0;
    for (int i = 0; i < 300; i++) send(bnd[1 + 3 * (i % 2)], 1'($urandom % 2));
    drain();
    @(negedge clk);
    chk("cnt_sat", {24'd0, ovf_count}, 32'd255);
    check_stats("cnt_sat_model");
    @(posedge clk); #1;
    clr_stat = 1'b1;
    send(16'h4000, 1'b1);
    clr_stat = 1'b0;
    @(negedge clk);
    chk("clr_cnt", {24'd0, ovf_count}, 32'd0);
    chk("clr_sticky", {31'd0, ovf_sticky}, 32'd0);
    @(posedge clk); #1;
    drain();

    // Reset with a full buffer discards everything.
    out_ready = 1'b0;
    send(16'h2000, 1'b1);
    send(16'hC000, 1'b0);
    @(negedge clk);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    chk("pre_rst_cnt", {24'd0, ovf_count}, 32'd2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expq.delete();
    @(negedge clk);
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst2_out_data", {21'd0, out_data}, 32'd0);
    check_stats("rst2");
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(16'hF000, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
